// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

  // Access size code used by the memory port.
  typedef logic [2:0] msize_t;
  // Byte write strobe. An all-zero strobe means a read.
  typedef logic [7:0] strobe_t;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Instruction fetches are always issued as a 32-bit word read.
  localparam msize_t ARB_ISIZE = 3'b010;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the ibus/dbus request/response and downstream memory signals.
// Latency: n/a (wiring only).
// Backpressure: the downstream port completes a beat with m_ready; the core buses hold valid until data_ok.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  // instruction bus
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  // data bus
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  strobe_t     dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  // downstream memory port
  logic        m_valid;
  logic [63:0] m_addr;
  msize_t      m_size;
  strobe_t     m_strobe;
  logic [63:0] m_data;
  logic        m_ready;
  logic [63:0] m_rdata;

  // arbiter side
  modport master (
    input  ireq_valid, ireq_addr,
    output iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_data_ok, dresp_data,
    output m_valid, m_addr, m_size, m_strobe, m_data,
    input  m_ready, m_rdata
  );

  // core + memory environment side
  modport slave (
    output ireq_valid, ireq_addr,
    input  iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_data_ok, dresp_data,
    input  m_valid, m_addr, m_size, m_strobe, m_data,
    output m_ready, m_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_perf.sv
// Saturating event counters for ibus grants, dbus grants and ibus wait cycles.
// Latency: each event is reflected in its counter one cycle after it is seen.
// Backpressure: none; counters stick at all-ones instead of wrapping.
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_igrant,
  input  logic        i_dgrant,
  input  logic        i_iwait,
  output logic [31:0] o_igrant_cnt,
  output logic [31:0] o_dgrant_cnt,
  output logic [31:0] o_iwait_cnt
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_igrant_cnt;
  logic [31:0] r_dgrant_cnt;
  logic [31:0] r_iwait_cnt;

  // count ibus grants, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_igrant_cnt <= '0;
    else if (i_igrant && r_igrant_cnt != CNT_MAX) r_igrant_cnt <= r_igrant_cnt + 32'd1;
  end

  // count dbus grants, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_dgrant_cnt <= '0;
    else if (i_dgrant && r_dgrant_cnt != CNT_MAX) r_dgrant_cnt <= r_dgrant_cnt + 32'd1;
  end

  // count cycles the ibus is requesting without owning the port, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_iwait_cnt <= '0;
    else if (i_iwait && r_iwait_cnt != CNT_MAX) r_iwait_cnt <= r_iwait_cnt + 32'd1;
  end

  assign o_igrant_cnt = r_igrant_cnt;
  assign o_dgrant_cnt = r_dgrant_cnt;
  assign o_iwait_cnt  = r_iwait_cnt;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat memory port between ibus and dbus; dbus first, starvation guard for ibus.
// Latency: request in IDLE cycle t -> m_valid at t+1; data_ok same cycle as m_ready; one IDLE bubble after.
// Backpressure: m_* held stable until m_ready; optional perf counters enabled by ARB_PERF_CNT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_igrant,
  output logic [31:0]       perf_dgrant,
  output logic [31:0]       perf_iwait
`endif
);

  localparam logic [1:0] S_IDLE   = ARB_IDLE;
  localparam logic [1:0] S_BUSY_I = ARB_BUSY_I;
  localparam logic [1:0] S_BUSY_D = ARB_BUSY_D;

  localparam int              CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

  logic [1:0]    r_state;
  logic          r_m_valid;
  logic [63:0]   r_m_addr;
  msize_t        r_m_size;
  strobe_t       r_m_strobe;
  logic [63:0]   r_m_data;
  logic [CW-1:0] r_starve_cnt;
  logic          r_abort;

  logic w_idle;
  logic w_busy_i;
  logic w_busy_d;
  logic w_force_i;
  logic w_grant_d;
  logic w_grant_i;
  logic w_done;
  logic w_owner_vld;
  logic w_ok_i;
  logic w_ok_d;

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy_i = (r_state == S_BUSY_I);
  assign w_busy_d = (r_state == S_BUSY_D);

  // ibus has waited through STARVE_MAX dbus grants: it goes next regardless of dbus
  assign w_force_i = bus.ireq_valid && (r_starve_cnt == STARVE_LIM);
  assign w_grant_d = w_idle && bus.dreq_valid && !w_force_i;
  assign w_grant_i = w_idle && bus.ireq_valid && !w_grant_d;

  // m_ready only matters while a request is out; it always retires the beat in one cycle
  assign w_done      = r_m_valid && bus.m_ready && !w_idle;
  assign w_owner_vld = w_busy_i ? bus.ireq_valid : bus.dreq_valid;

  // an owner that has let go (now, or earlier in this transaction) gets no response
  assign w_ok_i = w_done && w_busy_i && bus.ireq_valid && !r_abort;
  assign w_ok_d = w_done && w_busy_d && bus.dreq_valid && !r_abort;

  // FSM and downstream request registers: load on grant, hold until the beat retires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_m_valid  <= 1'b0;
      r_m_addr   <= '0;
      r_m_size   <= '0;
      r_m_strobe <= '0;
      r_m_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state    <= S_BUSY_D;
            r_m_valid  <= 1'b1;
            r_m_addr   <= bus.dreq_addr;
            r_m_size   <= bus.dreq_size;
            r_m_strobe <= bus.dreq_strobe;
            r_m_data   <= bus.dreq_data;
          end else if (w_grant_i) begin
            r_state    <= S_BUSY_I;
            r_m_valid  <= 1'b1;
            r_m_addr   <= bus.ireq_addr;
            r_m_size   <= ARB_ISIZE;
            r_m_strobe <= '0;
            r_m_data   <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (w_done) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  // starvation counter: dbus grants taken while ibus was waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d && bus.ireq_valid) begin
      if (r_starve_cnt != STARVE_LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else if (w_grant_i) begin
      r_starve_cnt <= '0;
    end else if (w_idle && !bus.ireq_valid) begin
      r_starve_cnt <= '0;
    end
  end

  // abort flag: owner dropped valid mid-transaction; cleared as the beat retires and in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_abort <= 1'b0;
    else        r_abort <= !w_idle && !w_done && (r_abort || !w_owner_vld);
  end

  assign bus.m_valid  = r_m_valid;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_size   = r_m_size;
  assign bus.m_strobe = r_m_strobe;
  assign bus.m_data   = r_m_data;

  assign bus.iresp_data_ok = w_ok_i;
  assign bus.iresp_data    = !w_ok_i     ? 32'd0 :
                             r_m_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
  assign bus.dresp_data_ok = w_ok_d;
  assign bus.dresp_data    = w_ok_d ? bus.m_rdata : 64'd0;

`ifdef ARB_PERF_CNT_EN
  logic w_iwait;
  assign w_iwait = bus.ireq_valid && !w_busy_i;

  mem_arb_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .i_igrant     (w_grant_i),
    .i_dgrant     (w_grant_d),
    .i_iwait      (w_iwait),
    .o_igrant_cnt (perf_igrant),
    .o_dgrant_cnt (perf_dgrant),
    .o_iwait_cnt  (perf_iwait)
  );
`endif

endmodule
